ooo_fu_completion_arbiter: RTL and testbench

Parametrised completion stage between the out-of-order execute units and commit. It replaces fixed per-unit result wires (one wen/rd/wdata/busy set per ALU, multiplier, divider and load/store unit) with NUM_FU generic channels. Each channel has a valid/ready handshake and a DEPTH-entry result FIFO. A round-robin arbiter serialises the buffered results onto one commit port, with stall-stable grant and a synchronous flush.

---
 rtl/ooo_fu_completion_arbiter.sv | 155 +++++++++++++++
 tb/tb_ooo_fu_completion_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ooo_fu_completion_arbiter.sv
// rtl/ooo_fu_completion_arbiter.sv - per-unit result FIFOs with round-robin, stall-stable commit arbitration
module ooo_fu_completion_arbiter #(
  parameter int NUM_FU  = 4,
  parameter int DEPTH   = 2,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int FU_ID_W = $clog2(NUM_FU)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU-1:0]        fu_wen,
  input  logic [NUM_FU-1:0]        fu_exc,
  input  logic [NUM_FU*RD_W-1:0]   fu_rd,
  input  logic [NUM_FU*DATA_W-1:0] fu_wdata,
  output logic [NUM_FU-1:0]        fu_busy,
  output logic                     cm_valid,
  input  logic                     cm_ready,
  output logic [FU_ID_W-1:0]       cm_fu_id,
  output logic                     cm_wen,
  output logic                     cm_exc,
  output logic [RD_W-1:0]          cm_rd,
  output logic [DATA_W-1:0]        cm_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 + RD_W + DATA_W;

  // Entry layout: {wen, exc, rd, wdata}
  logic [ENT_W-1:0]   r_mem   [NUM_FU][DEPTH];
  logic [PTR_W-1:0]   r_wptr  [NUM_FU];
  logic [PTR_W-1:0]   r_rptr  [NUM_FU];
  logic [CNT_W-1:0]   r_cnt   [NUM_FU];
  logic [FU_ID_W-1:0] r_rr_ptr;
  logic [FU_ID_W-1:0] r_lock_id;
  logic               r_lock;

  logic [NUM_FU-1:0]  w_nonempty;
  logic [NUM_FU-1:0]  w_ready;
  logic [NUM_FU-1:0]  w_push;
  logic [NUM_FU-1:0]  w_pop;
  logic [FU_ID_W-1:0] w_scan;
  logic               w_found;
  logic [FU_ID_W-1:0] w_idx;
  logic [FU_ID_W-1:0] w_grant;
  logic [FU_ID_W-1:0] w_grant_next;
  logic               w_hs;
  logic [ENT_W-1:0]   w_head;
  int                 w_sum;

  // Per-channel status from registered counts only; ready never looks at this cycle's pop
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      w_nonempty[i] = (r_cnt[i] != '0);
      w_ready[i]    = (r_cnt[i] != CNT_W'(DEPTH));
      w_push[i]     = fu_valid[i] && w_ready[i];
    end
  end

  // Round-robin scan: first non-empty channel starting at rr_ptr, wrapping mod NUM_FU
  always_comb begin
    w_scan  = r_rr_ptr;
    w_found = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_sum = int'(r_rr_ptr) + k;
      if (w_sum >= NUM_FU) begin
        w_sum = w_sum - NUM_FU;
      end
      w_idx = FU_ID_W'(w_sum);
      if (!w_found && w_nonempty[w_idx]) begin
        w_found = 1'b1;
        w_scan  = w_idx;
      end
    end
  end

  // A stalled grant is held so the commit payload cannot change under a pending handshake
  always_comb begin
    w_grant      = r_lock ? r_lock_id : w_scan;
    w_grant_next = (w_grant == FU_ID_W'(NUM_FU - 1)) ? '0 : w_grant + FU_ID_W'(1);
    w_hs         = cm_valid && cm_ready;
    for (int i = 0; i < NUM_FU; i++) begin
      w_pop[i] = w_hs && (w_grant == FU_ID_W'(i));
    end
  end

  assign cm_valid = (|w_nonempty) || r_lock;
  assign w_head   = r_mem[w_grant][r_rptr[w_grant]];
  assign cm_fu_id = w_grant;
  assign cm_wen   = w_head[ENT_W-1];
  assign cm_exc   = w_head[ENT_W-2];
  assign cm_rd    = w_head[DATA_W +: RD_W];
  assign cm_wdata = w_head[DATA_W-1:0];
  assign fu_ready = w_ready;
  assign fu_busy  = w_nonempty;

  // FIFO storage; stale writes during flush are harmless because the pointers are cleared
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= {fu_wen[i], fu_exc[i],
                                fu_rd[i*RD_W +: RD_W],
                                fu_wdata[i*DATA_W +: DATA_W]};
      end
    end
  end

  // FIFO pointers and counts; flush and reset discard everything including this cycle's push/pop
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        end
        if (w_push[i] && !w_pop[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else if (w_pop[i] && !w_push[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Arbiter state: advance past the winner on handshake, lock onto it on stall; flush keeps rr_ptr
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else if (flush) begin
      r_lock    <= 1'b0;
    end else if (w_hs) begin
      r_rr_ptr  <= w_grant_next;
      r_lock    <= 1'b0;
    end else if (cm_valid) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_grant;
    end
  end

endmodule

// File: tb/tb_ooo_fu_completion_arbiter.sv
// tb/tb_ooo_fu_completion_arbiter.sv - vector table, wrap sequence and randomized model check
module tb_ooo_fu_completion_arbiter;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int IW = 2;

  logic          CLK = 1'b0;
  logic          RST, flush, cm_ready;
  logic [N-1:0]  fu_valid, fu_wen, fu_exc, fu_ready, fu_busy;
  logic [N*RW-1:0] fu_rd;
  logic [N*DW-1:0] fu_wdata;
  logic          cm_valid, cm_wen, cm_exc;
  logic [IW-1:0] cm_fu_id;
  logic [RW-1:0] cm_rd;
  logic [DW-1:0] cm_wdata;

  ooo_fu_completion_arbiter #(.NUM_FU(N), .DEPTH(D), .DATA_W(DW), .RD_W(RW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_wen(fu_wen), .fu_exc(fu_exc),
    .fu_rd(fu_rd), .fu_wdata(fu_wdata), .fu_busy(fu_busy),
    .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_fu_id(cm_fu_id),
    .cm_wen(cm_wen), .cm_exc(cm_exc), .cm_rd(cm_rd), .cm_wdata(cm_wdata)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, fl;
    logic [3:0]  v;
    logic        rdy;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        chk;
    logic        e_val;
    logic [1:0]  e_id;
    logic [3:0]  e_rdy, e_busy;
    logic        e_pay;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mk(logic rst, logic fl, logic [3:0] v, logic rdy, logic [4:0] rd,
                              logic [31:0] wd, logic c, logic ev, logic [1:0] eid,
                              logic [3:0] erdy, logic [3:0] ebusy, logic ep,
                              logic [4:0] erd, logic [31:0] ewd);
    vec_t t;
    t.rst = rst; t.fl = fl; t.v = v; t.rdy = rdy; t.rd = rd; t.wd = wd;
    t.chk = c; t.e_val = ev; t.e_id = eid; t.e_rdy = erdy; t.e_busy = ebusy;
    t.e_pay = ep; t.e_rd = erd; t.e_wd = ewd;
    return t;
  endfunction

  // Same rd/wdata on every channel; wen follows valid, exc low
  task automatic drive_all(input logic rst, input logic fl, input logic [3:0] v,
                           input logic rdy, input logic [4:0] rd, input logic [31:0] wd);
    RST = rst; flush = fl; fu_valid = v; fu_wen = v; fu_exc = '0; cm_ready = rdy;
    for (int i = 0; i < N; i++) begin
      fu_rd[i*RW +: RW]    = rd;
      fu_wdata[i*DW +: DW] = wd;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  vec_t tbl[34];
  int   n_commit;

  // Reference model state
  logic [38:0] q[N][$];
  int          m_rr;
  bit          m_held;
  int          m_hid;

  initial begin
    tbl[0]  = mk(1,0,4'h0,0,0,0,              0,0,0,4'hF,4'h0,0,0,0);
    tbl[1]  = mk(0,0,4'h4,1,5,32'hDEADBEEF,   1,0,0,4'hF,4'h0,0,0,0);
    tbl[2]  = mk(0,0,4'h0,1,0,0,              1,1,2,4'hF,4'h4,1,5,32'hDEADBEEF);
    tbl[3]  = mk(0,0,4'h0,1,0,0,              1,0,0,4'hF,4'h0,0,0,0);
    tbl[4]  = mk(0,0,4'h1,0,1,32'h11,         1,0,0,4'hF,4'h0,0,0,0);
    tbl[5]  = mk(0,0,4'h1,0,2,32'h22,         1,1,0,4'hF,4'h1,1,1,32'h11);
    tbl[6]  = mk(0,0,4'h1,0,3,32'h33,         1,1,0,4'hE,4'h1,1,1,32'h11);
    tbl[7]  = mk(0,0,4'h0,1,0,0,              1,1,0,4'hE,4'h1,1,1,32'h11);
    tbl[8]  = mk(0,0,4'h0,0,0,0,              1,1,0,4'hF,4'h1,1,2,32'h22);
    tbl[9]  = mk(0,0,4'h0,1,0,0,              1,1,0,4'hF,4'h1,1,2,32'h22);
    tbl[10] = mk(1,0,4'h0,0,0,0,              1,0,0,4'hF,4'h0,0,0,0);
    tbl[11] = mk(0,0,4'hF,0,7,32'h77,         1,0,0,4'hF,4'h0,0,0,0);
    tbl[12] = mk(0,0,4'hF,0,7,32'h77,         1,1,0,4'hF,4'hF,1,7,32'h77);
    tbl[13] = mk(0,0,4'h0,1,0,0,              1,1,0,4'h0,4'hF,1,7,32'h77);
    tbl[14] = mk(0,0,4'h0,1,0,0,              1,1,1,4'h1,4'hF,1,7,32'h77);
    tbl[15] = mk(0,0,4'h0,1,0,0,              1,1,2,4'h3,4'hF,1,7,32'h77);
    tbl[16] = mk(0,0,4'h0,1,0,0,              1,1,3,4'h7,4'hF,1,7,32'h77);
    tbl[17] = mk(0,0,4'h0,1,0,0,              1,1,0,4'hF,4'hF,1,7,32'h77);
    tbl[18] = mk(0,0,4'h0,1,0,0,              1,1,1,4'hF,4'hE,1,7,32'h77);
    tbl[19] = mk(0,0,4'h0,1,0,0,              1,1,2,4'hF,4'hC,1,7,32'h77);
    tbl[20] = mk(0,0,4'h0,1,0,0,              1,1,3,4'hF,4'h8,1,7,32'h77);
    tbl[21] = mk(0,0,4'h8,0,9,32'h99,         1,0,0,4'hF,4'h0,0,0,0);
    tbl[22] = mk(0,0,4'h1,0,10,32'hAA,        1,1,3,4'hF,4'h8,1,9,32'h99);
    tbl[23] = mk(0,0,4'h0,0,0,0,              1,1,3,4'hF,4'h9,1,9,32'h99);
    tbl[24] = mk(0,0,4'h0,0,0,0,              1,1,3,4'hF,4'h9,1,9,32'h99);
    tbl[25] = mk(0,0,4'h0,1,0,0,              1,1,3,4'hF,4'h9,1,9,32'h99);
    tbl[26] = mk(0,0,4'h0,1,0,0,              1,1,0,4'hF,4'h1,1,10,32'hAA);
    tbl[27] = mk(0,0,4'hF,0,1,32'h1,          1,0,0,4'hF,4'h0,0,0,0);
    tbl[28] = mk(0,0,4'h1,0,2,32'h2,          1,1,1,4'hF,4'hF,1,1,32'h1);
    tbl[29] = mk(0,1,4'h4,1,3,32'h3,          1,1,1,4'hE,4'hF,1,1,32'h1);
    tbl[30] = mk(0,0,4'h0,1,0,0,              1,0,0,4'hF,4'h0,0,0,0);
    tbl[31] = mk(0,0,4'h2,1,4,32'h44,         1,0,0,4'hF,4'h0,0,0,0);
    tbl[32] = mk(0,0,4'h0,1,0,0,              1,1,1,4'hF,4'h2,1,4,32'h44);
    tbl[33] = mk(0,0,4'h0,1,0,0,              1,0,0,4'hF,4'h0,0,0,0);

    drive_all(1, 0, 0, 0, 0, 0);
    step();

    // Directed vector table
    n_commit = 0;
    for (int r = 0; r < 34; r++) begin
      drive_all(tbl[r].rst, tbl[r].fl, tbl[r].v, tbl[r].rdy, tbl[r].rd, tbl[r].wd);
      if (tbl[r].chk) begin
        chk($sformatf("row%0d cm_valid", r), 64'(cm_valid), 64'(tbl[r].e_val));
        chk($sformatf("row%0d fu_ready", r), 64'(fu_ready), 64'(tbl[r].e_rdy));
        chk($sformatf("row%0d fu_busy", r),  64'(fu_busy),  64'(tbl[r].e_busy));
        if (tbl[r].e_val) begin
          chk($sformatf("row%0d cm_fu_id", r), 64'(cm_fu_id), 64'(tbl[r].e_id));
        end
        if (tbl[r].e_pay) begin
          chk($sformatf("row%0d payload", r), {cm_wen, cm_exc, cm_rd, cm_wdata},
              {1'b1, 1'b0, tbl[r].e_rd, tbl[r].e_wd});
        end
      end
      if (cm_valid === 1'b1 && cm_ready && !flush && !RST) n_commit++;
      step();
    end
    chk("commit count excl flush cycle", 64'(n_commit), 64'd14);

    // Wrap-around: ten back-to-back push/pop pairs through channel 1
    for (int k = 1; k <= 11; k++) begin
      drive_all(0, 0, (k <= 10) ? 4'h2 : 4'h0, 1, 5'(k), 32'(k));
      if (k > 1) begin
        chk($sformatf("wrap%0d valid", k), 64'(cm_valid), 64'd1);
        chk($sformatf("wrap%0d id", k), 64'(cm_fu_id), 64'd1);
        chk($sformatf("wrap%0d data", k), 64'(cm_wdata), 64'(k - 1));
      end
      step();
    end
    chk("wrap drained", 64'(cm_valid), 64'd0);

    // Randomized run against the queue model
    drive_all(1, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < N; i++) q[i].delete();
    m_rr = 0; m_held = 0; m_hid = 0;
    for (int c = 0; c < 3000; c++) begin
      int          g;
      bit          ev;
      logic [3:0]  acc;
      logic [3:0]  erdy, ebusy;
      RST      = ($urandom_range(0, 299) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      fu_valid = 4'($urandom);
      fu_wen   = 4'($urandom);
      fu_exc   = 4'($urandom);
      cm_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        fu_rd[i*RW +: RW]    = 5'($urandom);
        fu_wdata[i*DW +: DW] = $urandom;
      end
      ev = m_held;
      g  = m_hid;
      if (!m_held) begin
        for (int k = 0; k < N; k++) begin
          int ch;
          ch = (m_rr + k) % N;
          if (!ev && q[ch].size() > 0) begin
            ev = 1; g = ch;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        erdy[i]  = (q[i].size() < D);
        ebusy[i] = (q[i].size() > 0);
      end
      chk("rnd cm_valid", 64'(cm_valid), 64'(ev));
      chk("rnd fu_ready", 64'(fu_ready), 64'(erdy));
      chk("rnd fu_busy",  64'(fu_busy),  64'(ebusy));
      if (ev) begin
        chk("rnd cm_fu_id", 64'(cm_fu_id), 64'(g));
        chk("rnd payload", 64'({cm_wen, cm_exc, cm_rd, cm_wdata}), 64'(q[g][0]));
      end
      if (RST || flush) begin
        for (int i = 0; i < N; i++) q[i].delete();
        m_held = 0;
        if (RST) m_rr = 0;
      end else begin
        for (int i = 0; i < N; i++) acc[i] = fu_valid[i] && (q[i].size() < D);
        if (ev && cm_ready) begin
          void'(q[g].pop_front());
          m_rr = (g + 1) % N;
          m_held = 0;
        end else if (ev) begin
          m_held = 1;
          m_hid = g;
        end
        for (int i = 0; i < N; i++) begin
          if (acc[i]) q[i].push_back({fu_wen[i], fu_exc[i], fu_rd[i*RW +: RW], fu_wdata[i*DW +: DW]});
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
